// File: rtl/time_set_ctrl.sv
// Time-setting controller: captures live time into shadow registers, lets the user edit
// hour/minute/second with inc/dec keys, and strobes the edited time back to the counters.
module time_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int BLINK_HALF     = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic [5:0] cur_second,
    input  logic [5:0] cur_minute,
    input  logic [4:0] cur_hour,
    output logic       set_time_en,
    output logic [5:0] set_time_second,
    output logic [5:0] set_time_minute,
    output logic [4:0] set_time_hour,
    output logic [1:0] edit_field,
    output logic       blink
);
    localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    typedef enum logic [2:0] {
        RUN,
        EDIT_H,
        EDIT_M,
        EDIT_S,
        COMMIT
    } state_e;

    state_e               state_q, state_d;
    logic [4:0]           hour_q, hour_d;
    logic [5:0]           minute_q, minute_d;
    logic [5:0]           second_q, second_d;
    logic                 en_q, en_d;
    logic [1:0]           field_q, field_d;
    logic                 blink_q, blink_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [BLINK_W-1:0]   bcnt_q, bcnt_d;

    logic       anyKey, editing, entering, timeout, stepUp, stepDn;
    logic [4:0] hourInc, hourDec;
    logic [5:0] minuteInc, minuteDec, secondInc, secondDec;

    function automatic logic isEdit(input state_e s);
        return (s == EDIT_H) || (s == EDIT_M) || (s == EDIT_S);
    endfunction

    assign anyKey  = key_mode | key_inc | key_dec;
    assign editing = isEdit(state_q);
    assign timeout = editing && !anyKey && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
    // Simultaneous inc+dec cancels out; mode always takes priority over both.
    assign stepUp  = key_inc & ~key_dec & ~key_mode;
    assign stepDn  = key_dec & ~key_inc & ~key_mode;

    assign hourInc   = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
    assign hourDec   = (hour_q == 5'd0 || hour_q > 5'd23) ? 5'd23 : hour_q - 5'd1;
    assign minuteInc = (minute_q >= 6'd59) ? 6'd0 : minute_q + 6'd1;
    assign minuteDec = (minute_q == 6'd0 || minute_q > 6'd59) ? 6'd59 : minute_q - 6'd1;
    assign secondInc = (second_q >= 6'd59) ? 6'd0 : second_q + 6'd1;
    assign secondDec = (second_q == 6'd0 || second_q > 6'd59) ? 6'd59 : second_q - 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
            en_q     <= 1'b0;
            field_q  <= 2'd0;
            blink_q  <= 1'b0;
            idle_q   <= '0;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            en_q     <= en_d;
            field_q  <= field_d;
            blink_q  <= blink_d;
            idle_q   <= idle_d;
            bcnt_q   <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (key_mode) state_d = EDIT_H;
            EDIT_H:  if (key_mode) state_d = EDIT_M; else if (timeout) state_d = RUN;
            EDIT_M:  if (key_mode) state_d = EDIT_S; else if (timeout) state_d = RUN;
            EDIT_S:  if (key_mode) state_d = COMMIT; else if (timeout) state_d = RUN;
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;
        case (state_q)
            RUN: begin
                if (key_mode) begin
                    hour_d   = (cur_hour > 5'd23)   ? 5'd0 : cur_hour;
                    minute_d = (cur_minute > 6'd59) ? 6'd0 : cur_minute;
                    second_d = (cur_second > 6'd59) ? 6'd0 : cur_second;
                end
            end
            EDIT_H: begin
                if (stepUp) hour_d = hourInc;
                else if (stepDn) hour_d = hourDec;
            end
            EDIT_M: begin
                if (stepUp) minute_d = minuteInc;
                else if (stepDn) minute_d = minuteDec;
            end
            EDIT_S: begin
                if (stepUp) second_d = secondInc;
                else if (stepDn) second_d = secondDec;
            end
            default: ;
        endcase

        en_d = (state_d == COMMIT);
        case (state_d)
            EDIT_H:  field_d = 2'd1;
            EDIT_M:  field_d = 2'd2;
            EDIT_S:  field_d = 2'd3;
            default: field_d = 2'd0;
        endcase

        // Blink phase and idle timer both restart whenever a new edit field is entered.
        entering = isEdit(state_d) && (state_d != state_q);
        if (!isEdit(state_d)) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (entering) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BLINK_W'(BLINK_HALF - 1)) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            blink_d = blink_q;
            bcnt_d  = bcnt_q + BLINK_W'(1);
        end

        if (!isEdit(state_d) || entering || anyKey) idle_d = '0;
        else idle_d = idle_q + IDLE_W'(1);
    end

    assign set_time_en     = en_q;
    assign set_time_hour   = hour_q;
    assign set_time_minute = minute_q;
    assign set_time_second = second_q;
    assign edit_field      = field_q;
    assign blink           = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: expected outputs are queued as each step is driven
// and checked with immediate assertions once the clock edge has produced the result.
module tb_time_set_ctrl;
    localparam int TO = 8;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       key_dec = 1'b0;
    logic [5:0] cur_second = '0;
    logic [5:0] cur_minute = '0;
    logic [4:0] cur_hour = '0;
    logic       set_time_en;
    logic [5:0] set_time_second;
    logic [5:0] set_time_minute;
    logic [4:0] set_time_hour;
    logic [1:0] edit_field;
    logic       blink;

    time_set_ctrl #(.TIMEOUT_CYCLES(TO), .BLINK_HALF(BH)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_mode        (key_mode),
        .key_inc         (key_inc),
        .key_dec         (key_dec),
        .cur_second      (cur_second),
        .cur_minute      (cur_minute),
        .cur_hour        (cur_hour),
        .set_time_en     (set_time_en),
        .set_time_second (set_time_second),
        .set_time_minute (set_time_minute),
        .set_time_hour   (set_time_hour),
        .edit_field      (edit_field),
        .blink           (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] f;
        logic       b;
    } exp_t;

    exp_t       sbQ[$];
    string      tagQ[$];
    int         evalCount = 0;
    int         failCount = 0;
    int         editAge = 0;
    logic [1:0] prevField = 2'd0;

    task automatic checkOutput();
        exp_t  e;
        string tag;
        evalCount++;
        assert (sbQ.size() > 0) else begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty observed %0d entries expected at least 1", sbQ.size());
        end
        if (sbQ.size() > 0) begin
            e   = sbQ.pop_front();
            tag = tagQ.pop_front();
            evalCount++;
            assert (set_time_en === e.en) else begin
                failCount++;
                $error("[TB] FAIL %s.set_time_en observed %0d expected %0d", tag, set_time_en, e.en);
            end
            evalCount++;
            assert (set_time_hour === e.h) else begin
                failCount++;
                $error("[TB] FAIL %s.hour observed %0d expected %0d", tag, set_time_hour, e.h);
            end
            evalCount++;
            assert (set_time_minute === e.m) else begin
                failCount++;
                $error("[TB] FAIL %s.minute observed %0d expected %0d", tag, set_time_minute, e.m);
            end
            evalCount++;
            assert (set_time_second === e.s) else begin
                failCount++;
                $error("[TB] FAIL %s.second observed %0d expected %0d", tag, set_time_second, e.s);
            end
            evalCount++;
            assert (edit_field === e.f) else begin
                failCount++;
                $error("[TB] FAIL %s.edit_field observed %0d expected %0d", tag, edit_field, e.f);
            end
            evalCount++;
            assert (blink === e.b) else begin
                failCount++;
                $error("[TB] FAIL %s.blink observed %0d expected %0d", tag, blink, e.b);
            end
        end
    endtask

    // Blink is expected high for the first BH cycles after entering a field, then alternating.
    task automatic applyStimulus(input logic r, input logic m, input logic i, input logic d,
                                 input string tag, input logic eEn, input logic [4:0] eH,
                                 input logic [5:0] eM, input logic [5:0] eS, input logic [1:0] eF);
        exp_t e;
        @(negedge clk);
        rst      = r;
        key_mode = m;
        key_inc  = i;
        key_dec  = d;
        if (eF == 2'd0 || eF != prevField) editAge = 0;
        else editAge++;
        prevField = eF;
        e.en = eEn;
        e.h  = eH;
        e.m  = eM;
        e.s  = eS;
        e.f  = eF;
        e.b  = (eF != 2'd0) && (((editAge / BH) % 2) == 0);
        sbQ.push_back(e);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        key_dec  = 1'b0;
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed no completion expected finish before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cur_hour = 5'd12; cur_minute = 6'd34; cur_second = 6'd56;
        applyStimulus(1, 0, 0, 0, "reset",           0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, "run_inc_ignored", 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, "mode_to_hour",    0, 12, 34, 56, 1);
        applyStimulus(0, 1, 0, 0, "mode_to_minute",  0, 12, 34, 56, 2);
        applyStimulus(0, 1, 0, 0, "mode_to_second",  0, 12, 34, 56, 3);
        applyStimulus(0, 1, 0, 0, "commit",          1, 12, 34, 56, 0);
        applyStimulus(0, 0, 0, 0, "run_hold",        0, 12, 34, 56, 0);

        cur_hour = 5'd23; cur_minute = 6'd0; cur_second = 6'd10;
        applyStimulus(0, 1, 0, 0, "capture_23",       0, 23, 0, 10, 1);
        applyStimulus(0, 0, 1, 0, "hour_wrap_up",     0, 0, 0, 10, 1);
        applyStimulus(0, 0, 0, 1, "hour_wrap_down",   0, 23, 0, 10, 1);
        applyStimulus(0, 0, 0, 1, "hour_dec",         0, 22, 0, 10, 1);
        applyStimulus(0, 0, 0, 0, "blink_phase",      0, 22, 0, 10, 1);
        applyStimulus(0, 1, 0, 0, "mode_to_minute2",  0, 22, 0, 10, 2);
        applyStimulus(0, 0, 0, 1, "minute_wrap_down", 0, 22, 59, 10, 2);
        applyStimulus(0, 0, 1, 1, "inc_dec_together", 0, 22, 59, 10, 2);
        applyStimulus(0, 1, 1, 0, "mode_beats_inc",   0, 22, 59, 10, 3);
        for (int k = 0; k < TO - 1; k++)
            applyStimulus(0, 0, 0, 0, "idle_wait",    0, 22, 59, 10, 3);
        applyStimulus(0, 0, 0, 0, "timeout_to_run",   0, 22, 59, 10, 0);
        applyStimulus(0, 0, 0, 0, "no_commit_after_timeout", 0, 22, 59, 10, 0);

        cur_hour = 5'd5; cur_minute = 6'd6; cur_second = 6'd7;
        applyStimulus(0, 1, 0, 0, "capture_5",        0, 5, 6, 7, 1);
        for (int k = 0; k < TO - 1; k++)
            applyStimulus(0, 0, 0, 0, "idle_hour",    0, 5, 6, 7, 1);
        applyStimulus(0, 0, 1, 0, "inc_at_timeout",   0, 6, 6, 7, 1);
        applyStimulus(0, 0, 0, 0, "still_editing",    0, 6, 6, 7, 1);
        applyStimulus(0, 1, 0, 0, "to_minute3",       0, 6, 6, 7, 2);
        applyStimulus(0, 1, 0, 0, "to_second3",       0, 6, 6, 7, 3);
        applyStimulus(1, 1, 0, 0, "reset_in_edit",    0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, "no_commit_after_reset", 0, 0, 0, 0, 0);

        cur_hour = 5'd31; cur_minute = 6'd63; cur_second = 6'd62;
        applyStimulus(0, 1, 0, 0, "capture_out_of_range", 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the number of idle cycles in any edit state before the edit is abandoned.
REQ-002 The block SHALL have parameter BLINK_HALF, default 250, meaning the number of cycles per blink phase while editing.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port key_mode  input  1  one-cycle pulse (debounced upstream) that advances the edit field.
REQ-006 The block SHALL have port key_inc  input  1  one-cycle pulse that increments the field under edit.
REQ-007 The block SHALL have port key_dec  input  1  one-cycle pulse that decrements the field under edit.
REQ-008 The block SHALL have port cur_second  input  6  live seconds from the time counters.
REQ-009 The block SHALL have port cur_minute  input  6  live minutes from the time counters.
REQ-010 The block SHALL have port cur_hour  input  5  live hours from the time counters.
REQ-011 The block SHALL have port set_time_en  output  1  one-cycle load strobe to the counters.
REQ-012 The block SHALL have port set_time_second  output  6  shadow seconds value.
REQ-013 The block SHALL have port set_time_minute  output  6  shadow minutes value.
REQ-014 The block SHALL have port set_time_hour  output  5  shadow hours value.
REQ-015 The block SHALL have port edit_field  output  2  field under edit: 0 none, 1 hour, 2 minute, 3 second.
REQ-016 The block SHALL have port blink  output  1  display blink phase for the field under edit.

Function
REQ-017 The FSM SHALL have states RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT, and all outputs SHALL be registered.
REQ-018 In RUN, key_mode SHALL capture cur_hour/minute/second into the shadow registers and go to EDIT_H; key_inc/key_dec SHALL be ignored.
REQ-019 During capture, out-of-range live values (hour>23, min/sec>59) SHALL be loaded as 0.
REQ-020 key_mode SHALL advance EDIT_H->EDIT_M->EDIT_S->COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle with set_time_en=1, then the FSM SHALL return to RUN; set_time_en SHALL be 0 in all other states.
REQ-022 In an edit state, key_inc SHALL increment the selected shadow field with wrap: hour 23->0, min/sec 59->0.
REQ-023 In an edit state, key_dec SHALL decrement the selected shadow field with wrap: hour 0->23, min/sec 0->59.
REQ-024 The shadow change SHALL be visible on set_time_* one cycle after the key pulse.
REQ-025 If key_inc and key_dec are asserted in the same cycle, the shadow value SHALL not change, and the cycle SHALL count as key activity.
REQ-026 If key_mode coincides with key_inc/key_dec, key_mode SHALL win and the inc/dec SHALL be ignored.
REQ-027 edit_field SHALL be 1/2/3 in EDIT_H/EDIT_M/EDIT_S and 0 in RUN and COMMIT.
REQ-028 The idle timer SHALL clear on entry to any edit state and on any key pulse, and SHALL increment otherwise while editing.
REQ-029 When the idle timer reaches TIMEOUT_CYCLES-1 with no key pulse in that cycle, the FSM SHALL return to RUN without COMMIT; the shadows SHALL hold and set_time_en SHALL stay 0.
REQ-030 A key pulse in the same cycle as the timeout SHALL be processed normally and the timeout SHALL be cancelled.
REQ-031 The blink counter SHALL run only in edit states, toggling blink every BLINK_HALF cycles starting at blink=1 on edit entry, and SHALL be forced to 0 in RUN/COMMIT.
REQ-032 set_time_* SHALL hold the last shadow values in RUN.

Reset
REQ-033 rst=1 at a clock edge SHALL force state RUN, shadows 0, set_time_en 0, edit_field 0, blink 0, and the idle and blink counters 0, overriding any simultaneous key pulse.
REQ-034 Reset asserted during an edit or COMMIT SHALL abort with no set_time_en pulse in the following cycle.

Verification
REQ-035 Bench SHALL apply reset, then with cur=12:34:56 pulse mode, mode, mode, mode -> edit_field sequence 1,2,3,0, and exactly one set_time_en pulse with 12:34:56.
REQ-036 Bench SHALL, in EDIT_H from 23, pulse inc -> hour 0; pulse dec twice -> hour 22; in EDIT_M from 0, pulse dec -> 59.
REQ-037 Bench SHALL, with TIMEOUT_CYCLES=8, enter edit then idle 8 cycles -> RUN, edit_field 0, and no set_time_en.
REQ-038 Bench SHALL, with TIMEOUT_CYCLES=8, pulse inc on the 8th idle cycle -> value incremented and still editing.
REQ-039 Bench SHALL pulse inc+dec together -> no change; pulse mode+inc together -> field advances with the value unchanged.
REQ-040 Bench SHALL assert rst in EDIT_S -> next cycle all outputs 0 and no set_time_en.
